l2_line_adaptor: RTL and testbench
==================================

# l2_line_adaptor

Converts full-line L2 cache transactions into fixed-length bursts on the physical-memory port. It sits directly downstream of the L2 data array and L2 control. It serialises a dirty line read from the data array into write beats. It assembles read beats into a full line, which L2 control writes back into the data array with all write-enable bits set.

## Interface

- s_offset, 5: log2 bytes per cache line (line = 8·2^s_offset bits, 256 by default)
- s_beat, 3: log2 bytes per memory beat (beat = 8·2^s_beat bits, 64 by default); beats per line = 2^(s_offset−s_beat), default 4

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst = 0 resets on the clock edge)
- address_i  in  32  line address from L2 control
- read_i  in  1  line-fill request
- write_i  in  1  line-writeback request
- line_i  in  s_line  line to write back, from the data array
- line_o  out  s_line  assembled fill line
- resp_o  out  1  one-cycle completion pulse
- address_o  out  32  memory address
- read_o  out  1  memory read burst active
- write_o  out  1  memory write burst active
- burst_o  out  8·2^s_beat  current write beat
- burst_i  in  8·2^s_beat  current read beat
- resp_i  in  1  memory beat handshake (one per beat)

## Operation

- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If write_i = 1, latch address_i and line_i, clear the beat counter, and go to WR_BURST.
  - Otherwise, if read_i = 1, latch address_i, clear the beat counter, and go to RD_BURST.
  - Write has priority when both requests are high; the read is served after the write because L2 control holds read_i.
- RD_BURST:
  - read_o = 1 and address_o = latched address with offset bits [s_offset−1:0] zeroed.
  - On each resp_i, store burst_i into line slot [beat·W +: W] and increment the beat counter.
  - On resp_i with the counter at its last value, go to DONE.
- WR_BURST:
  - write_o = 1 and address_o is the same as in RD_BURST.
  - burst_o = latched line slot for the current beat.
  - Advance and exit on resp_i exactly as in RD_BURST.
- DONE: resp_o = 1 and read_o = write_o = 0; go to IDLE next cycle.
- line_o is driven from the assembly register. After a read, it holds the filled line until the next read's first beat overwrites slot 0. A write never modifies it.
- resp_i is ignored in IDLE and DONE.
- The beat counter is 2^(s_offset−s_beat) states wide and wraps to 0 after the last beat.
- L2 control deasserts its request in the cycle resp_o = 1. A request still high in the following IDLE cycle starts a new transaction; this is legal, not an error.
- address_i and line_i changing mid-burst have no effect, because both are latched.

## Timing

- Reset values: resp_o = 0, read_o = 0, write_o = 0, address_o = 0, burst_o = 0, line_o = 0; state = IDLE; counter = 0.
- Zero-wait memory (resp_i high every cycle):
  - request seen at cycle T;
  - read_o or write_o high over T+1..T+4;
  - resp_o high at T+5;
  - IDLE at T+6.
- Minimum latency is beats+1 cycles. Each cycle with resp_i low adds one cycle.
- burst_o changes only on the edge following a resp_i.
- Reset mid-burst returns to IDLE next edge with all outputs at reset values. No resp_o is generated and the partial line is discarded. The memory side is reset concurrently.

## Configuration

- L2_ADAPTOR_WRAP_EN defined: critical-word-first wrapped bursts.
  - The counter starts at address_i[s_offset−1:s_beat] and wraps modulo beats; the transaction still ends after exactly `beats` handshakes.
  - address_o keeps the beat-offset bits (bits [s_beat−1:0] zero) for the whole burst.
  - Read beats and write beats map to slot (start+k) mod beats.
- L2_ADAPTOR_WRAP_EN undefined: bursts always start at beat 0, and address_o is line-aligned as described above.

## Test plan

- Reset: hold rst = 0 for 2 cycles with read_i = 1 → all outputs 0 and no burst starts; release → read_o rises one cycle later.
- Zero-wait read:
  - Stimulus: address_i = 0x0000_1234; beats 0x11…11, 0x22…22, 0x33…33, 0x44…44.
  - Response: address_o = 0x0000_1220; resp_o at T+5; line_o = {0x44…,0x33…,0x22…,0x11…}.
- Stalled write:
  - Stimulus: line_i = {0xD…,0xC…,0xB…,0xA…}; resp_i high every other cycle.
  - Response: burst_o sequence A, B, C, D, each held for 2 cycles; write_o high for 8 cycles; a single resp_o.
- Simultaneous read_i = write_i = 1 → write burst first, then after resp_o and IDLE a read burst; line_o is unchanged by the write.
- Reset mid-burst: rst = 0 after beat 2 of a read → no resp_o; line_o = 0; the next read completes normally.
- WRAP_EN (macro defined): read at 0x0000_1230 → slots filled in order 2, 3, 0, 1; address_o = 0x0000_1230; line_o is identical to an aligned read of the same data.

Source files
------------

// File: rtl/l2_line_adaptor_if.sv
// l2_line_adaptor_if
//   Bundles the L2-side request/line signals and the physical-memory burst
//   signals of l2_line_adaptor. Port names keep the original _i/_o suffixes,
//   which are relative to the adaptor.
//   Parameters:
//     s_offset : log2 bytes per cache line (line = 8*2^s_offset bits)
//     s_beat   : log2 bytes per memory beat (beat = 8*2^s_beat bits)
//   Modports:
//     master : the adaptor (drives the memory burst and the L2 response)
//     slave  : L2 control, data array and memory environment
interface l2_line_adaptor_if #(
    parameter int s_offset = 5,
    parameter int s_beat   = 3
);
    localparam int S_LINE  = 8 << s_offset;
    localparam int S_BURST = 8 << s_beat;

    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic [S_LINE-1:0]  line_i;
    logic [S_LINE-1:0]  line_o;
    logic               resp_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic [S_BURST-1:0] burst_o;
    logic [S_BURST-1:0] burst_i;
    logic               resp_i;

    modport master (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    modport slave (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/l2_line_adaptor.sv
// l2_line_adaptor
//   Converts full-line L2 transactions into fixed-length memory bursts.
//   A writeback serialises the latched line into write beats; a fill
//   assembles read beats into line_o. One resp_o pulse per transaction.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-low reset
//     bus  : l2_line_adaptor_if.master (L2 request/line + memory burst)
//   Configuration:
//     L2_ADAPTOR_WRAP_EN : critical-word-first wrapped bursts starting at
//                          the beat addressed by address_i; undefined gives
//                          line-aligned bursts starting at beat 0.
module l2_line_adaptor #(
    parameter int s_offset = 5,
    parameter int s_beat   = 3
) (
    input  logic              clk,
    input  logic              rst,
    l2_line_adaptor_if.master bus
);
    localparam int S_LINE = 8 << s_offset;
    localparam int W      = 8 << s_beat;
    localparam int CW     = s_offset - s_beat;

`ifdef L2_ADAPTOR_WRAP_EN
    localparam int ALIGN = s_beat;
`else
    localparam int ALIGN = s_offset;
`endif
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << ALIGN) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       addr_q;
    logic [S_LINE-1:0] wline_q;
    logic [S_LINE-1:0] rline_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_start;
    logic [CW-1:0]     cnt_last;
    logic              last_beat;

    // The burst ends on the beat just before the start beat (mod beats),
    // which is the all-ones beat when bursts start at 0.
`ifdef L2_ADAPTOR_WRAP_EN
    assign cnt_start = bus.address_i[s_offset-1:s_beat];
    assign cnt_last  = addr_q[s_offset-1:s_beat] - CW'(1);
`else
    assign cnt_start = '0;
    assign cnt_last  = '1;
`endif

    assign last_beat = bus.resp_i && (cnt_q == cnt_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.write_i) begin
                    state_nxt = WR_BURST;
                end else if (bus.read_i) begin
                    state_nxt = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address is stored already aligned so address_o needs no masking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.write_i || bus.read_i) begin
                        addr_q <= bus.address_i & ADDR_MASK;
                        cnt_q  <= cnt_start;
                    end
                    if (bus.write_i) begin
                        wline_q <= bus.line_i;
                    end
                end
                RD_BURST: begin
                    if (bus.resp_i) begin
                        rline_q[int'(cnt_q)*W +: W] <= bus.burst_i;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WR_BURST: begin
                    if (bus.resp_i) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.read_o    = (state == RD_BURST);
        bus.write_o   = (state == WR_BURST);
        bus.resp_o    = (state == DONE);
        bus.address_o = addr_q;
        bus.line_o    = rline_q;
        bus.burst_o   = wline_q[int'(cnt_q)*W +: W];
    end
endmodule

// File: tb/tb_l2_line_adaptor.sv
// tb_l2_line_adaptor
//   Self-checking bench for l2_line_adaptor. Acts as L2 control and as the
//   physical memory; memory holds one line (mem[slot]) and returns the beat
//   belonging to the slot being transferred. Honours L2_ADAPTOR_WRAP_EN.
module tb_l2_line_adaptor;
    localparam int S_OFFSET = 5;
    localparam int S_BEAT   = 3;
    localparam int LW = 8 << S_OFFSET;
    localparam int BW = 8 << S_BEAT;
    localparam int NB = 1 << (S_OFFSET - S_BEAT);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    l2_line_adaptor_if #(.s_offset(S_OFFSET), .s_beat(S_BEAT)) bus ();

    l2_line_adaptor #(.s_offset(S_OFFSET), .s_beat(S_BEAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [LW-1:0] exp_line = '0;
    logic [BW-1:0] mem [NB];

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LW-1:0] mem_line();
        logic [LW-1:0] v;
        for (int i = 0; i < NB; i++) v[i*BW +: BW] = mem[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef L2_ADAPTOR_WRAP_EN
        return a & ~32'(BW / 8 - 1);
`else
        return a & ~32'(LW / 8 - 1);
`endif
    endfunction

    function automatic int start_beat(input logic [31:0] a);
`ifdef L2_ADAPTOR_WRAP_EN
        return int'((a / (BW / 8)) % NB);
`else
        return 0 * int'(a[0]);
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp"},  bus.resp_o,    '0);
        check({tag, "_rd"},    bus.read_o,    '0);
        check({tag, "_wr"},    bus.write_o,   '0);
        check({tag, "_addr"},  bus.address_o, '0);
        check({tag, "_burst"}, bus.burst_o,   '0);
        check({tag, "_line"},  bus.line_o,    '0);
    endtask

    // Called at a negedge while the DUT is idle. stall: 0 none, 1 every other
    // cycle, 2 random. abort_at > 0 resets after that many handshakes.
    task automatic do_txn(input bit is_wr, input bit hold_rd, input logic [31:0] a,
                          input logic [LW-1:0] wl, input int stall, input int abort_at);
        int start, k, cyc, slot;
        bit r;
        start = start_beat(a);
        bus.address_i = a;
        bus.line_i    = wl;
        bus.resp_i    = 1'b0;
        if (is_wr) bus.write_i = 1'b1;
        else       bus.read_i  = 1'b1;
        if (hold_rd) bus.read_i = 1'b1;
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < NB) begin
            slot = (start + k) % NB;
            check("busy",  is_wr ? bus.write_o : bus.read_o, 1'b1);
            check("other", is_wr ? bus.read_o : bus.write_o, 1'b0);
            check("resp_early", bus.resp_o, 1'b0);
            check("addr", bus.address_o, exp_addr(a));
            if (is_wr) check("burst_o", bus.burst_o, wl[slot*BW +: BW]);
            if (abort_at > 0 && k == abort_at) begin
                rst = 1'b0;
                bus.resp_i = 1'b1;
                @(negedge clk);
                check_reset_outputs("midrst");
                exp_line = '0;
                rst = 1'b1;
                bus.read_i  = 1'b0;
                bus.write_i = 1'b0;
                bus.resp_i  = 1'b0;
                @(negedge clk);
                check("midrst_idle_rd", bus.read_o, 1'b0);
                check("midrst_noresp", bus.resp_o, 1'b0);
                return;
            end
            case (stall)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 1);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            bus.resp_i  = r;
            bus.burst_i = r ? mem[slot] : {$urandom, $urandom};
            bus.address_i = $urandom;
            bus.line_i    = rnd_line();
            @(negedge clk);
            if (r) k++;
            cyc++;
            if (cyc > 200) begin
                check("timeout", 1'b0, 1'b1);
                return;
            end
        end
        if (!is_wr) exp_line = mem_line();
        check("resp_done", bus.resp_o, 1'b1);
        check("done_rd", bus.read_o, 1'b0);
        check("done_wr", bus.write_o, 1'b0);
        check("line_done", bus.line_o, exp_line);
        bus.write_i = 1'b0;
        if (!hold_rd) bus.read_i = 1'b0;
        bus.resp_i  = 1'($urandom);
        @(negedge clk);
        check("resp_pulse", bus.resp_o, 1'b0);
        check("idle_rd", bus.read_o, 1'b0);
        check("idle_wr", bus.write_o, 1'b0);
        check("line_idle", bus.line_o, exp_line);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.resp_i = 1'($urandom);
            @(negedge clk);
            check("gap_rd", bus.read_o, 1'b0);
            check("gap_wr", bus.write_o, 1'b0);
            check("gap_resp", bus.resp_o, 1'b0);
        end
        bus.resp_i = 1'b0;
    endtask

    task automatic rnd_mem();
        for (int i = 0; i < NB; i++) mem[i] = {$urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] wl;
        bus.address_i = '0;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b0;
        bus.line_i    = '0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;

        // Reset held with a pending read: nothing may start.
        @(negedge clk);
        check_reset_outputs("rst1");
        @(negedge clk);
        check_reset_outputs("rst2");
        rst = 1'b1;

        // Zero-wait read at 0x1234, read_o rises one cycle after release.
        mem[0] = {16{4'h1}};
        mem[1] = {16{4'h2}};
        mem[2] = {16{4'h3}};
        mem[3] = {16{4'h4}};
        do_txn(1'b0, 1'b0, 32'h0000_1234, '0, 0, 0);
        check("fill_line", bus.line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        // Stalled write: each beat held for two cycles.
        wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        do_txn(1'b1, 1'b0, 32'h0000_4000, wl, 1, 0);

        // Simultaneous requests: write first, then the held read.
        rnd_mem();
        do_txn(1'b1, 1'b1, 32'h0000_5040, rnd_line(), 0, 0);
        do_txn(1'b0, 1'b0, 32'h0000_6060, '0, 2, 0);

        // Reset after beat 2 of a read, then a normal read.
        rnd_mem();
        do_txn(1'b0, 1'b0, 32'h0000_7000, '0, 0, 2);
        rnd_mem();
        do_txn(1'b0, 1'b0, 32'h0000_7020, '0, 2, 0);

        // Read at a non-zero beat offset (wrapped when enabled).
        mem[0] = {16{4'h1}};
        mem[1] = {16{4'h2}};
        mem[2] = {16{4'h3}};
        mem[3] = {16{4'h4}};
        do_txn(1'b0, 1'b0, 32'h0000_1230, '0, 0, 0);
        check("wrap_line", bus.line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        for (int t = 0; t < 40; t++) begin
            bit is_wr;
            is_wr = 1'($urandom);
            rnd_mem();
            if (is_wr && ($urandom_range(0, 3) == 0)) begin
                do_txn(1'b1, 1'b1, $urandom, rnd_line(), 2, 0);
                rnd_mem();
                do_txn(1'b0, 1'b0, $urandom, '0, 2, 0);
            end else begin
                do_txn(is_wr, 1'b0, $urandom, rnd_line(), 2, 0);
            end
            idle_gap(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
